param_serializer: RTL
=====================

PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0; 0 sends LSB first, 1 sends MSB first.
REQ-003 The block SHALL have parameter PAR_ODD, default 0; 0 selects even parity, 1 selects odd parity (used only under SER_PARITY_EN).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port p_data  input  DATA_W  parallel word to serialize.
REQ-007 Port data_valid  input  1  p_data is valid this cycle.
REQ-008 Port busy  input  1  downstream frame in progress; blocks loading.
REQ-009 Port ser_en  input  1  shift enable; one bit is emitted per enabled cycle.
REQ-010 Port ser_data  output  1  registered serial bit.
REQ-011 Port ser_done  output  1  one-cycle pulse marking the final data bit.
REQ-012 Port loaded  output  1  high while a captured word is held or being shifted.
REQ-013 Port par_bit  output  1  registered parity of the captured word (present only with SER_PARITY_EN).

Function
REQ-014 The FSM SHALL have states IDLE, LOADED and SHIFT; loaded SHALL be high in LOADED and SHIFT.
REQ-015 In IDLE, data_valid=1 and busy=0 SHALL capture p_data into the shift register, clear the bit counter and move to LOADED.
REQ-016 data_valid SHALL be ignored in LOADED and SHIFT, even when busy=0; the held word is never overwritten.
REQ-017 In LOADED or SHIFT, each edge with ser_en=1 SHALL drive ser_data with the next bit (bit 0 upward if MSB_FIRST=0, bit DATA_W-1 downward if MSB_FIRST=1), increment the counter and enter or stay in SHIFT.
REQ-018 Each edge with ser_en=0 in SHIFT SHALL hold the state, counter, shift register and ser_data (pause, not abort).
REQ-019 The edge that emits bit number DATA_W SHALL set ser_done=1 for exactly one cycle and return the FSM to IDLE.
REQ-020 After that edge, ser_data SHALL hold the last bit until the next shift.
REQ-021 ser_en=1 in IDLE SHALL have no effect on ser_data or the counter.
REQ-022 A load SHALL be accepted in IDLE on the edge immediately after ser_done, so back-to-back words are possible.
REQ-023 The counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never exceed DATA_W.

Reset
REQ-024 rst=0 SHALL asynchronously force: state IDLE, counter 0, shift register 0, ser_data 0, ser_done 0, loaded 0, par_bit 0.
REQ-025 Reset during SHIFT SHALL discard the word; there SHALL be no ser_done pulse for it.
REQ-026 Outputs SHALL leave their reset values only on clock edges after rst rises.

Configuration
REQ-027 With macro SER_PARITY_EN defined, par_bit SHALL be computed at load as XOR of p_data (inverted if PAR_ODD=1) and held until the next load or reset.
REQ-028 Without SER_PARITY_EN, the par_bit port and its logic SHALL be absent, and PAR_ODD SHALL have no effect.

Structure
REQ-029 The state encoding (IDLE=2'b00, LOADED=2'b01, SHIFT=2'b10) and the DATA_W legal-range constants SHALL live in shared package ser_pkg.
REQ-030 The bit counter with its terminal-count compare SHALL be sub-module ser_bit_counter; the rest of the logic SHALL be flat.

Verification
REQ-031 DATA_W=8, MSB_FIRST=0: load 0xA5, then 8 ser_en cycles -> ser_data 1,0,1,0,0,1,0,1; ser_done high only on cycle 8.
REQ-032 MSB_FIRST=1: load 0xA5 -> ser_data 1,0,1,0,0,1,0,1 MSB first, ser_done on bit 8.
REQ-033 Load 0x3C, shift 3 bits, drop ser_en for 5 cycles, resume -> remaining 5 bits correct, with no extra or missing ser_done.
REQ-034 Load with busy=1 -> no capture, loaded stays 0; data_valid=0x FF during SHIFT -> the word in flight is unchanged.
REQ-035 Assert rst after bit 4 of 0xF0 -> all outputs 0 immediately; no ser_done; a fresh load of 0x0F then serializes correctly.
REQ-036 SER_PARITY_EN, DATA_W=16: load 0x0001 -> par_bit=1 with PAR_ODD=0; load 0x0003 -> par_bit=1 with PAR_ODD=1.

Source files
------------

// File: rtl/ser_pkg.sv
// ============================================================================
// Module  : ser_pkg
// Purpose : Shared FSM encoding and word-width limits for param_serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOADED = 2'b01,
        SHIFT  = 2'b10
    } ser_state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;

endpackage : ser_pkg

`default_nettype wire

// File: rtl/ser_bit_counter.sv
// ============================================================================
// Module  : ser_bit_counter
// Purpose : Emitted-bit counter with terminal-count flag for param_serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_bit_counter #(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != C_MAX)) begin
            // Saturating so the count can never pass DATA_W.
            count <= count + 1'b1;
        end
    end

    // High while the next increment emits the final data bit.
    assign last = (count == C_LAST);

endmodule : ser_bit_counter

`default_nettype wire

// File: rtl/param_serializer.sv
// ============================================================================
// Module  : param_serializer
// Purpose : Parallel-to-serial converter with pause support and done pulse.
//           Optional parity output enabled by macro SER_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module param_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int PAR_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    input  logic              busy,
    input  logic              ser_en,
    output logic              ser_data,
    output logic              ser_done,
    output logic              loaded
`ifdef SER_PARITY_EN
    ,
    output logic              par_bit
`endif
);

    generate
        if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
            $error("param_serializer: DATA_W out of range");
        end
        if (PAR_ODD != 0 && PAR_ODD != 1) begin : g_bad_par_odd
            $error("param_serializer: PAR_ODD must be 0 or 1");
        end
    endgenerate

    ser_state_t        state;
    ser_state_t        state_next;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shifted;
    logic              next_bit;
    logic              load_now;
    logic              shift_now;
    logic              last;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign next_bit     = sreg[DATA_W-1];
            assign sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign next_bit     = sreg[0];
            assign sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
        end
    endgenerate

    assign load_now  = (state == IDLE) && data_valid && !busy;
    assign shift_now = (state != IDLE) && ser_en;

    ser_bit_counter #(
        .DATA_W (DATA_W)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_now),
        .inc  (shift_now),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_now) begin
                    state_next = LOADED;
                end
            end
            LOADED, SHIFT: begin
                if (ser_en) begin
                    state_next = last ? IDLE : SHIFT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ser_data keeps its value whenever no bit is emitted, including in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg     <= '0;
            ser_data <= 1'b0;
            ser_done <= 1'b0;
        end else begin
            ser_done <= shift_now && last;
            if (load_now) begin
                sreg <= p_data;
            end else if (shift_now) begin
                sreg     <= sreg_shifted;
                ser_data <= next_bit;
            end
        end
    end

    assign loaded = (state != IDLE);

`ifdef SER_PARITY_EN
    localparam logic C_PAR_ODD = (PAR_ODD != 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (load_now) begin
            par_bit <= (^p_data) ^ C_PAR_ODD;
        end
    end
`endif

endmodule : param_serializer

`default_nettype wire
